// File: rtl/cam_ctrl_if.sv
// Command/response channel, occupancy status and CAM pin bundle for cam_ctrl.
// The slave modport is the controller; the master modport is the host logic
// together with the CAM instance that answers the cam_* pins.
interface cam_ctrl_if #(
  parameter int SIZE_ADDR = 4
) ();

  // Host command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [7:0]           cmd_key;
  logic [SIZE_ADDR-1:0] cmd_idx;

  // Host response channel
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [SIZE_ADDR-1:0] rsp_idx;
  logic                 rsp_err;

  // Occupancy status
  logic [SIZE_ADDR:0]   count;
  logic                 full;

  // CAM pins
  logic                 cam_enable;
  logic                 cam_write;
  logic [4:0]           cam_addr;
  logic [7:0]           cam_data;
  logic [4:0]           cam_out;
  logic                 cam_found;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_idx, rsp_ready, cam_out, cam_found,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err, count, full,
           cam_enable, cam_write, cam_addr, cam_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_idx, rsp_ready, cam_out, cam_found,
    output cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err, count, full,
           cam_enable, cam_write, cam_addr, cam_data
  );

endinterface

// File: rtl/cam_ctrl.sv
// Command-side initiator for a 16-entry, 8-bit-key CAM. Accepts lookup,
// insert and delete commands, keeps valid keys unique, allocates the
// lowest free slot, and returns one response per command. Key 0x00 marks a
// free entry, so it can never be looked up or inserted.
module cam_ctrl #(
  parameter int NB_MEM    = 16,
  parameter int SIZE_ADDR = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  cam_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOOK,
    SAMP,
    WR,
    RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  localparam logic [SIZE_ADDR:0] FULL_COUNT = (SIZE_ADDR+1)'(NB_MEM);

  state_t               r_state;
  state_t               w_state_next;

  op_t                  r_op;
  logic [7:0]           r_key;
  logic [SIZE_ADDR-1:0] r_target;
  logic [NB_MEM-1:0]    r_valid;
  logic [SIZE_ADDR:0]   r_count;
  logic                 r_full;
  logic                 r_rsp_hit;
  logic [SIZE_ADDR-1:0] r_rsp_idx;
  logic                 r_rsp_err;

  logic                 w_cmd_err;
  logic                 w_hit;
  logic [SIZE_ADDR-1:0] w_free_idx;
  logic                 w_cmd_ready;
  logic                 w_rsp_valid;
  logic                 w_cam_enable;
  logic                 w_cam_write;
  logic [SIZE_ADDR-1:0] w_cam_addr;
  logic [7:0]           w_cam_data;

  // Reserved opcode, or a zero key on lookup/insert, is rejected at accept.
  assign w_cmd_err = (bus.cmd_op == OP_RSVD) ||
                     ((bus.cmd_op != OP_DELETE) && (bus.cmd_key == 8'h00));

  // A CAM match counts only if it points at an in-range, occupied entry.
  assign w_hit = bus.cam_found &&
                 (bus.cam_out[4:SIZE_ADDR] == '0) &&
                 r_valid[bus.cam_out[SIZE_ADDR-1:0]];

  // Lowest-index free entry: scan downward so the lowest match wins.
  always_comb begin
    w_free_idx = '0;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = SIZE_ADDR'(i);
    end
  end

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and CAM/handshake output decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_cam_enable = 1'b0;
    w_cam_write  = 1'b0;
    w_cam_addr   = '0;
    w_cam_data   = 8'h00;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (w_cmd_err)                   w_state_next = RSP;
          else if (bus.cmd_op == OP_DELETE) w_state_next = WR;
          else                              w_state_next = LOOK;
        end
      end
      LOOK: begin
        w_cam_enable = 1'b1;
        w_cam_data   = r_key;
        w_state_next = SAMP;
      end
      SAMP: begin
        w_cam_data = r_key;
        if ((r_op == OP_LOOKUP) || w_hit || r_full) w_state_next = RSP;
        else                                         w_state_next = WR;
      end
      WR: begin
        w_cam_write  = 1'b1;
        w_cam_addr   = r_target;
        w_cam_data   = (r_op == OP_INSERT) ? r_key : 8'h00;
        w_state_next = RSP;
      end
      RSP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Command capture, occupancy tracking and response formation.
  // NOTE: the occupancy vector is only NB_MEM flops, so it is reset directly;
  // that keeps it consistent with the CAM, which clears on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_LOOKUP;
      r_key     <= 8'h00;
      r_target  <= '0;
      r_valid   <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_rsp_hit <= 1'b0;
      r_rsp_idx <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_op      <= op_t'(bus.cmd_op);
            r_key     <= bus.cmd_key;
            r_target  <= bus.cmd_idx;
            r_rsp_hit <= 1'b0;
            r_rsp_idx <= '0;
            r_rsp_err <= w_cmd_err;
          end
        end
        SAMP: begin
          if (r_op == OP_LOOKUP) begin
            r_rsp_hit <= w_hit;
            r_rsp_idx <= w_hit ? bus.cam_out[SIZE_ADDR-1:0] : '0;
          end else if (w_hit) begin
            r_rsp_hit <= 1'b1;
            r_rsp_idx <= bus.cam_out[SIZE_ADDR-1:0];
          end else if (r_full) begin
            r_rsp_err <= 1'b1;
          end else begin
            r_target <= w_free_idx;
          end
        end
        WR: begin
          r_rsp_idx <= r_target;
          if (r_op == OP_INSERT) begin
            r_valid[r_target] <= 1'b1;
            r_count           <= r_count + 1'b1;
            r_full            <= ((r_count + 1'b1) == FULL_COUNT);
            r_rsp_hit         <= 1'b0;
          end else begin
            r_valid[r_target] <= 1'b0;
            r_rsp_hit         <= r_valid[r_target];
            if (r_valid[r_target]) begin
              r_count <= r_count - 1'b1;
              r_full  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_hit    = r_rsp_hit;
  assign bus.rsp_idx    = r_rsp_idx;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.cam_enable = w_cam_enable;
  assign bus.cam_write  = w_cam_write;
  assign bus.cam_addr   = {1'b0, w_cam_addr};
  assign bus.cam_data   = w_cam_data;

endmodule

// File: tb/tb_cam_ctrl.sv
// Testbench for cam_ctrl: a behavioural CAM answers the cam_* pins, and a
// key-table model of the controller predicts every response, latency and
// CAM write. Directed steps follow the feature list, then random commands.
module tb_cam_ctrl;

  localparam int NB_MEM    = 16;
  localparam int SIZE_ADDR = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cam_ctrl_if #(.SIZE_ADDR(SIZE_ADDR)) bus ();

  cam_ctrl #(.NB_MEM(NB_MEM), .SIZE_ADDR(SIZE_ADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural CAM: combinational match index, registered found flag.
  logic [7:0] cam_mem [NB_MEM];
  logic       cam_found_q;
  logic [4:0] cam_match_idx;
  logic       cam_match_any;

  always_comb begin
    cam_match_idx = '0;
    cam_match_any = 1'b0;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (cam_mem[i] == bus.cam_data) begin
        cam_match_idx = 5'(i);
        cam_match_any = 1'b1;
      end
    end
  end

  assign bus.cam_out   = cam_match_idx;
  assign bus.cam_found = cam_found_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_MEM; i++) cam_mem[i] <= 8'h00;
      cam_found_q <= 1'b0;
    end else begin
      if (bus.cam_write)  cam_mem[bus.cam_addr[3:0]] <= bus.cam_data;
      if (bus.cam_enable) cam_found_q <= cam_match_any;
    end
  end

  // Write monitor.
  int         wr_cnt       = 0;
  logic [4:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  always @(posedge clk) begin
    if (rst_n && bus.cam_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.cam_addr;
      last_wr_data <= bus.cam_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: key stored per slot, 0x00 meaning free.
  logic [7:0] ref_key [NB_MEM];

  function automatic int ref_count();
    int n = 0;
    for (int i = 0; i < NB_MEM; i++) if (ref_key[i] != 8'h00) n++;
    return n;
  endfunction

  function automatic int find_key(input logic [7:0] key);
    for (int i = 0; i < NB_MEM; i++) if (ref_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < NB_MEM; i++) if (ref_key[i] == 8'h00) return i;
    return -1;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < NB_MEM; i++) ref_key[i] = 8'h00;
  endtask

  // Issue one command, predict its outcome, and check the response.
  // hold: cycles rsp_ready stays low while the response is presented.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] key,
                         input logic [3:0] idx, input int hold, input string tag);
    logic       e_hit;
    logic       e_err;
    logic [3:0] e_idx;
    int         e_lat;
    int         e_wr;
    int         j;
    int         wr0;
    int         lat;

    e_hit = 1'b0;
    e_err = 1'b0;
    e_idx = '0;
    e_wr  = 0;
    e_lat = 3;
    if (op == 2'b11 || (op != 2'b10 && key == 8'h00)) begin
      e_err = 1'b1;
      e_lat = 1;
    end else if (op == 2'b10) begin
      e_hit        = (ref_key[idx] != 8'h00);
      e_idx        = idx;
      ref_key[idx] = 8'h00;
      e_lat        = 2;
      e_wr         = 1;
    end else begin
      j = find_key(key);
      if (j >= 0) begin
        e_hit = 1'b1;
        e_idx = 4'(j);
      end else if (op == 2'b01) begin
        j = find_free();
        if (j < 0) e_err = 1'b1;
        else begin
          ref_key[j] = key;
          e_idx      = 4'(j);
          e_lat      = 4;
          e_wr       = 1;
        end
      end
    end

    @(negedge clk);
    check({tag, ".cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    bus.cmd_idx   = idx;
    wr0           = wr_cnt;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".latency"},   32'(lat),           32'(e_lat));
    check({tag, ".hit"},       32'(bus.rsp_hit),   32'(e_hit));
    check({tag, ".idx"},       32'(bus.rsp_idx),   32'(e_idx));
    check({tag, ".err"},       32'(bus.rsp_err),   32'(e_err));
    check({tag, ".count"},     32'(bus.count),     32'(ref_count()));
    check({tag, ".full"},      32'(bus.full),      32'(ref_count() == NB_MEM));
    check({tag, ".writes"},    32'(wr_cnt - wr0),  32'(e_wr));
    check({tag, ".cmd_ready_rsp"}, 32'(bus.cmd_ready), 32'd0);
    if (e_wr == 1) begin
      check({tag, ".wr_addr"}, 32'(last_wr_addr), {27'd0, 1'b0, e_idx});
      check({tag, ".wr_data"}, 32'(last_wr_data), (op == 2'b10) ? 32'd0 : 32'(key));
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(bus.cmd_ready), 32'd0);
      check({tag, ".hold_hit"},   32'(bus.rsp_hit),   32'(e_hit));
      check({tag, ".hold_idx"},   32'(bus.rsp_idx),   32'(e_idx));
      check({tag, ".hold_err"},   32'(bus.rsp_err),   32'(e_err));
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, ".rsp_drop"},  32'(bus.rsp_valid), 32'd0);
    check({tag, ".back_idle"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] r_op;
    logic [7:0] r_key;
    int         r_sel;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_key   = 8'h00;
    bus.cmd_idx   = '0;
    bus.rsp_ready = 1'b0;
    ref_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.cmd_ready",  32'(bus.cmd_ready),  32'd1);
    check("reset.rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("reset.rsp_hit",    32'(bus.rsp_hit),    32'd0);
    check("reset.rsp_idx",    32'(bus.rsp_idx),    32'd0);
    check("reset.rsp_err",    32'(bus.rsp_err),    32'd0);
    check("reset.count",      32'(bus.count),      32'd0);
    check("reset.full",       32'(bus.full),       32'd0);
    check("reset.cam_enable", 32'(bus.cam_enable), 32'd0);
    check("reset.cam_write",  32'(bus.cam_write),  32'd0);
    check("reset.cam_addr",   32'(bus.cam_addr),   32'd0);
    check("reset.cam_data",   32'(bus.cam_data),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic lookup/insert/duplicate/error cases
    run_cmd(2'b00, 8'h5A, 4'd0, 0, "lookup_empty");
    run_cmd(2'b01, 8'h5A, 4'd0, 0, "insert_5a");
    run_cmd(2'b01, 8'h33, 4'd0, 0, "insert_33");
    run_cmd(2'b00, 8'h33, 4'd0, 0, "lookup_33");
    run_cmd(2'b01, 8'h5A, 4'd0, 0, "insert_dup");
    run_cmd(2'b00, 8'h00, 4'd0, 0, "lookup_zero");
    run_cmd(2'b01, 8'h00, 4'd0, 0, "insert_zero");
    run_cmd(2'b11, 8'h12, 4'd3, 0, "op_reserved");

    // Delete and reallocate
    run_cmd(2'b10, 8'h00, 4'd0, 0, "delete_0");
    run_cmd(2'b01, 8'h77, 4'd0, 0, "insert_77");
    run_cmd(2'b00, 8'h5A, 4'd0, 0, "lookup_deleted");

    // Empty the table (also deletes free entries), then fill it
    for (int i = 0; i < NB_MEM; i++) run_cmd(2'b10, 8'h00, 4'(i), 0, "clear");
    for (int i = 0; i < NB_MEM; i++) run_cmd(2'b01, 8'(i + 1), 4'd0, 0, "fill");
    run_cmd(2'b01, 8'h99, 4'd0, 0, "insert_full");
    run_cmd(2'b00, 8'h10, 4'd0, 0, "lookup_last");
    run_cmd(2'b10, 8'h00, 4'd7, 0, "delete_7");
    run_cmd(2'b01, 8'h99, 4'd0, 0, "insert_into_7");

    // Response held while rsp_ready stays low
    run_cmd(2'b00, 8'h99, 4'd0, 5, "hold");

    // Reset asserted while the controller is in LOOK
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_key   = 8'h05;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("midrst.in_look", 32'(bus.cam_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("midrst.cmd_ready",  32'(bus.cmd_ready),  32'd1);
    check("midrst.count",      32'(bus.count),      32'd0);
    check("midrst.full",       32'(bus.full),       32'd0);
    check("midrst.cam_enable", 32'(bus.cam_enable), 32'd0);
    ref_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'b00, 8'h05, 4'd0, 0, "after_rst_lookup");
    run_cmd(2'b00, 8'h99, 4'd0, 0, "after_rst_lookup2");

    // Random commands over a small key pool so hits, fills and deletes recur
    for (int n = 0; n < 200; n++) begin
      r_sel = $urandom_range(0, 9);
      if (r_sel < 4)      r_op = 2'b01;
      else if (r_sel < 7) r_op = 2'b00;
      else if (r_sel < 9) r_op = 2'b10;
      else                r_op = 2'b11;
      r_key = 8'($urandom_range(0, 22));
      run_cmd(r_op, r_key, 4'($urandom_range(0, NB_MEM - 1)),
              ($urandom_range(0, 7) == 0) ? 2 : 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Command-side initiator for the 16-entry, 8-bit-key CAM. Drives the CAM's enable, write, addr and data pins, and consumes its out and found results.
- Exposes a valid/ready command channel (lookup, insert, delete) and a valid/ready response channel to the host logic.
- Tracks entry occupancy, keeps valid entries unique, and allocates free slots.
- Key 0x00 is reserved as the "empty" marker, so stale or free entries never produce false matches.

Parameters:
- NB_MEM, 16, number of CAM entries; must match the CAM instance.
- SIZE_ADDR, 4, entry index width, equal to log2(NB_MEM).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, async active-low reset; shared with the CAM instance.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
- cmd_op, input, 2, command opcode: 00 lookup, 01 insert, 10 delete, 11 reserved.
- cmd_key, input, 8, search or insert key.
- cmd_idx, input, SIZE_ADDR, entry index for delete.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high.
- rsp_hit, output, 1, lookup/insert: key already present; delete: entry was valid.
- rsp_idx, output, SIZE_ADDR, matched, allocated or deleted index.
- rsp_err, output, 1, command rejected.
- count, output, SIZE_ADDR+1, number of valid entries.
- full, output, 1, high when count == NB_MEM.
- cam_enable, output, 1, drives CAM enable.
- cam_write, output, 1, drives CAM write.
- cam_addr, output, 5, drives CAM addr; bit 4 is tied to 0.
- cam_data, output, 8, drives CAM data.
- cam_out, input, 5, CAM match index; combinational from cam_data.
- cam_found, input, 1, CAM registered found flag; updated one cycle after cam_enable.

Behaviour:
- Reset (rst_n is asynchronous):
  - State goes to IDLE; valid[NB_MEM-1:0] clears to 0.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_err=0, count=0, full=0, cam_enable=0, cam_write=0, cam_addr=0, cam_data=0.
  - The CAM resets all entries to 0x00 on the same edge, so the "free entry holds 0x00" invariant holds.
  - Reset mid-operation abandons the command; no response is issued.
- State machine states: IDLE, LOOK, SAMP, WR, RSP.
- IDLE:
  - cmd_ready=1; all other CAM controls are 0.
  - On accept, the command fields are registered.
  - op=11, or key==0x00 with op 00 or 01 -> RSP with rsp_err=1, rsp_hit=0, rsp_idx=0.
  - op=10 (delete) -> WR.
  - Otherwise -> LOOK.
- LOOK (1 cycle): cam_enable=1, cam_write=0, cam_data=key.
- SAMP (1 cycle):
  - cam_enable=0, cam_data still equals key; cam_found is now valid for this key.
  - hit = cam_found && valid[cam_out[SIZE_ADDR-1:0]].
  - Lookup -> RSP with rsp_hit=hit and rsp_idx=(hit ? cam_out : 0).
  - Insert with hit -> RSP with rsp_hit=1 and rsp_idx=cam_out; no write, so duplicates are never stored.
  - Insert with miss and full -> RSP with rsp_err=1.
  - Insert with miss and not full -> WR, with the target set to the lowest-index entry where valid=0 (priority encoder).
- WR (1 cycle):
  - cam_write=1, cam_enable=0, cam_addr={0, target}.
  - Insert: cam_data=key; valid[target] is set; response is rsp_hit=0, rsp_idx=target.
  - Delete: cam_data=0x00; response is rsp_hit=old valid[cmd_idx], rsp_idx=cmd_idx, and valid[cmd_idx] is cleared.
  - Deleting an already-free entry is legal: it rewrites 0x00, count is unchanged, rsp_hit=0.
  - Next state: RSP.
- RSP:
  - rsp_valid=1; response fields are held stable; cmd_ready=0.
  - On rsp_ready -> IDLE, and rsp_valid drops the next cycle.
  - Back-to-back throughput is limited to one command per IDLE visit.
- Latency from the accept edge to rsp_valid:
  - lookup, or insert that hits: 3 cycles
  - insert with write: 4 cycles
  - delete: 2 cycles
  - error: 1 cycle
- count and full are registered and updated in the same cycle valid changes.
- Invariant: valid entries hold unique non-zero keys and free entries hold 0x00. Because lookup/insert keys are non-zero, at most one entry matches, so cam_out is an exact index.

Test Plan:
- Reset, then lookup 0x5A -> rsp_valid 3 cycles after accept; rsp_hit=0, rsp_idx=0, rsp_err=0, count=0.
- Insert 0x5A, then insert 0x33 -> responses idx=0 then idx=1, both with rsp_hit=0, 4-cycle latency; count=2. Then lookup 0x33 -> rsp_hit=1, rsp_idx=1.
- Insert 0x5A again -> rsp_hit=1, rsp_idx=0, no cam_write pulse, count stays 2. Lookup 0x00 or op=11 -> rsp_err=1 after 1 cycle.
- Delete idx=0 -> rsp_hit=1, count=1, CAM write of 0x00 observed. Insert 0x77 -> rsp_idx=0. Lookup 0x5A -> rsp_hit=0.
- Insert 16 distinct keys 0x01..0x10 -> idx 0..15, then full=1, count=16. Insert 0x99 -> rsp_err=1, no write. Delete idx=7 -> full=0; insert 0x99 -> rsp_idx=7.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout. Assert rst_n while in LOOK -> state IDLE, count=0, rsp_valid=0; a following lookup of any prior key misses.
